log_conv: RTL
=============

LOG_CONV -- requirements
Module: log_conv

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning linear operand width in bits (must be ≥ 2).
REQ-002 SHALL have parameter KEEP_WIDTH, default 5, meaning retained fractional mantissa bits (1 ≤ KEEP_WIDTH ≤ WIDTH-1).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  unsigned linear operand.
REQ-008 SHALL have port out_valid  output  1  out_k, out_x and out_zero are valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_k  output  $clog2(WIDTH)  characteristic, i.e. the leading-one position, range 0..WIDTH-1.
REQ-011 SHALL have port out_x  output  KEEP_WIDTH  truncated fractional mantissa.
REQ-012 SHALL have port out_zero  output  1  operand was zero; log undefined.

Function
REQ-013 SHALL compute out_k as the index of the most significant set bit of in_data.
REQ-014 SHALL form out_x from the bits below the leading one, MSB-aligned, truncated (no rounding) to KEEP_WIDTH bits.
REQ-015 SHALL zero-fill the LSBs of out_x when out_k < KEEP_WIDTH.
REQ-016 SHALL, for in_data == 0, drive out_zero=1, out_k=0 and out_x=0; out_zero SHALL be 0 otherwise.
REQ-017 SHALL make out_k/out_x directly consumable by antilog_conv after log-domain addition, with {1,out_x} reconstructing the normalized mantissa.
REQ-018 SHALL be a two-stage pipeline: stage 1 = leading-one detection (registers k, zero flag, operand); stage 2 = normalize shift and truncation (registers out_*).
REQ-019 SHALL have a latency of exactly 2 cycles from input acceptance to out_valid when out_ready is held high.
REQ-020 SHALL sustain a throughput of 1 result/cycle when out_ready is high.
REQ-021 SHALL define a transfer as valid && ready high in the same cycle, on either port.
REQ-022 SHALL advance stage N when that stage is empty or its contents transfer downstream in the same cycle (ready_N = !valid_N || ready_N+1).
REQ-023 SHALL drive in_ready = !valid_s1 || ready_s2; in_ready MAY depend combinationally on out_ready, and in_ready SHALL NOT depend on in_valid.
REQ-024 SHALL, once out_valid is asserted, hold out_valid, out_k, out_x and out_zero stable until the transfer occurs.
REQ-025 SHALL buffer up to 2 accepted operands while out_ready is low; in_ready SHALL drop only when both stages are full.
REQ-026 SHALL, on a simultaneous output drain and input accept, lose and duplicate no data and keep results in order.
REQ-027 SHALL ignore in_data when in_valid is low; a stage's data registers MAY hold stale values while that stage is invalid.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear both stage valid bits, so out_valid=0 and in_ready=1 once rst_n is released.
REQ-029 SHALL reset out_k, out_x and out_zero to 0.
REQ-030 SHALL discard in-flight operands on reset mid-operation, with no output for them after rst_n rises.
REQ-031 SHALL accept input on the first rising clk edge after rst_n deasserts.

Structure
REQ-032 SHALL take from the shared package log_mult_pkg: the default WIDTH and KEEP_WIDTH constants, and the K_W = $clog2(WIDTH) width helper shared with antilog_conv.
REQ-033 SHALL instantiate a purely combinational priority encoder as sub-module lod (leading_one_detector), outputting position and zero flag.
REQ-034 SHALL contain no other sub-modules; the pipeline control SHALL be local to log_conv.

Verification (WIDTH=16, KEEP_WIDTH=5, out_ready=1 unless stated)
REQ-035 SHALL cover: in_data=0x0001 -> out_k=0, out_x=00000, out_zero=0, 2 cycles after acceptance.
REQ-036 SHALL cover: 0x00B4 -> out_k=7, out_x=01101; 0xFFFF -> out_k=15, out_x=11111; 0x0006 -> out_k=2, out_x=10000.
REQ-037 SHALL cover: in_data=0x0000 -> out_zero=1, out_k=0, out_x=0.
REQ-038 SHALL cover: out_ready=0 with inputs 0x0100, 0x0300, 0x0700 offered back-to-back -> first two accepted, in_ready=0 for the third, outputs held stable; release out_ready -> results k=8,9,10 with x=00000, 10000, 11000 in order, no gaps.
REQ-039 SHALL cover: continuous random in_valid/out_ready over 10k operands -> every output matches the reference model in order, with no loss or duplication.
REQ-040 SHALL cover: rst_n pulsed low with both stages full -> out_valid=0 immediately, in_ready=1 after release, and no stale result ever emitted.

Source files
------------

// File: rtl/log_mult_pkg.sv
// Shared constants and width helper for the log-domain multiplier (log_conv / antilog_conv).
package log_mult_pkg;

    localparam int LOG_WIDTH      = 16;
    localparam int LOG_KEEP_WIDTH = 5;

    // Width of the characteristic field; a 1-bit operand still needs a 1-bit field.
    function automatic int k_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: position of the most significant set bit, plus an all-zero flag.
// Zero latency; no flow control.
module leading_one_detector #(
    parameter int WIDTH = 16,
    parameter int POS_W = 4
) (
    input  logic [WIDTH-1:0] data,
    output logic [POS_W-1:0] pos,
    output logic             zero
);

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/log_conv.sv
// Linear-to-log converter: {k, x} = characteristic and truncated mantissa; 2-cycle latency, 1/cycle.
// Valid/ready pipeline with per-stage skid-free advance; holds up to 2 operands under backpressure.
module log_conv
    import log_mult_pkg::*;
#(
    parameter int WIDTH      = LOG_WIDTH,
    parameter int KEEP_WIDTH = LOG_KEEP_WIDTH,
    localparam int K_W       = k_w(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K_W-1:0]        out_k,
    output logic [KEEP_WIDTH-1:0] out_x,
    output logic                  out_zero
);

    logic [K_W-1:0]   lod_pos;
    logic             lod_zero;

    logic             s1_vld;
    logic [K_W-1:0]   s1_k;
    logic             s1_zero;
    logic [WIDTH-1:0] s1_dat;
    logic             s2_rdy;

    leading_one_detector #(
        .WIDTH (WIDTH),
        .POS_W (K_W)
    ) lod (
        .data  (in_data),
        .pos   (lod_pos),
        .zero  (lod_zero)
    );

    assign s2_rdy   = !out_valid || out_ready;
    assign in_ready = !s1_vld || s2_rdy;

    // Stage 1: leading-one position, zero flag and the raw operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_k    <= '0;
            s1_zero <= 1'b0;
            s1_dat  <= '0;
        end else if (in_ready) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_k    <= lod_pos;
                s1_zero <= lod_zero;
                s1_dat  <= in_data;
            end
        end
    end

    // Stage 2: appending KEEP_WIDTH zeros then shifting right by k lands the bits just
    // below the leading one in the low KEEP_WIDTH positions, zero-filled when k is small.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_k     <= '0;
            out_x     <= '0;
            out_zero  <= 1'b0;
        end else if (s2_rdy) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                out_k    <= s1_k;
                out_zero <= s1_zero;
                out_x    <= KEEP_WIDTH'({s1_dat, {KEEP_WIDTH{1'b0}}} >> s1_k);
            end
        end
    end

endmodule
